// File: rtl/bpdecode_bram_arb.sv
// Two-requester arbiter sharing the BP decoder's single-port BRAM between the host
// path and the decode core, with locked decoder bursts and owner-tagged read return.
module bpdecode_bram_arb #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 1,
   parameter int MAX_HOLD = 16
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   output logic              h_gnt,
   output logic              h_rvalid,
   output logic [DATA_W-1:0] h_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_lock,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata,
   input  logic              cnt_clr,
   output logic [15:0]       conflict_cnt
);

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   logic              r_prio_d;
   logic [7:0]        r_hold;
   logic [15:0]       r_conflict_cnt;
   logic [RD_LAT-1:0] r_vld_p;
   logic [RD_LAT-1:0] r_own_p;

   logic w_hold_full;
   logic w_d_wins;
   logic w_conflict;
   logic w_rd_acc;
   logic w_lock_acc;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_hold(input logic [7:0] v);
      return (v >= HOLD_MAX) ? HOLD_MAX : v + 8'd1;
   endfunction

   // Grant decision: a full hold counter strips the decoder of its priority
   assign w_conflict  = h_req & d_req;
   assign w_hold_full = (r_hold >= HOLD_MAX);
   assign w_d_wins    = r_prio_d & ~w_hold_full;
   assign d_gnt       = ~ARESET & d_req & (~h_req | w_d_wins);
   assign h_gnt       = ~ARESET & h_req & ~(d_req & w_d_wins);
   assign w_lock_acc  = d_gnt & d_lock & h_req;
   assign w_rd_acc    = (h_gnt & ~h_we) | (d_gnt & ~d_we);

   assign bram_en    = h_gnt | d_gnt;
   assign bram_we    = (h_gnt & h_we) | (d_gnt & d_we);
   assign bram_addr  = d_gnt ? d_addr  : h_addr;
   assign bram_wdata = d_gnt ? d_wdata : h_wdata;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_prio_d <= 1'b1;
         r_hold   <= 8'd0;
      end else begin
         if (h_gnt)
            r_prio_d <= 1'b1;
         else if (d_gnt)
            r_prio_d <= d_lock;
         r_hold <= w_lock_acc ? sat_hold(r_hold) : 8'd0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET | cnt_clr)
         r_conflict_cnt <= 16'd0;
      else if (w_conflict)
         r_conflict_cnt <= sat_inc16(r_conflict_cnt);
   end

   // Read-return pipeline: tag 1 marks a decoder-owned read
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_vld_p <= '0;
         r_own_p <= '0;
      end else begin
         r_vld_p[0] <= w_rd_acc;
         r_own_p[0] <= d_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld_p[i] <= r_vld_p[i-1];
            r_own_p[i] <= r_own_p[i-1];
         end
      end
   end

   assign h_rvalid     = r_vld_p[RD_LAT-1] & ~r_own_p[RD_LAT-1];
   assign d_rvalid     = r_vld_p[RD_LAT-1] &  r_own_p[RD_LAT-1];
   assign h_rdata      = bram_rdata;
   assign d_rdata      = bram_rdata;
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_bpdecode_bram_arb.sv
// Scoreboard bench for bpdecode_bram_arb: rule-level arbitration model plus a
// reference memory; a monitor matches returned reads against queued expectations.
module tb_bpdecode_bram_arb;

   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 32;
   localparam int RD_LAT   = 2;
   localparam int MAX_HOLD = 4;

   logic              clk = 1'b0;
   logic              ARESET = 1'b1;
   logic              h_req = 0, h_we = 0, d_req = 0, d_we = 0, d_lock = 0, cnt_clr = 0;
   logic [ADDR_W-1:0] h_addr = '0, d_addr = '0;
   logic [DATA_W-1:0] h_wdata = '0, d_wdata = '0;
   logic              h_gnt, h_rvalid, d_gnt, d_rvalid, bram_en, bram_we;
   logic [DATA_W-1:0] h_rdata, d_rdata, bram_wdata, bram_rdata;
   logic [ADDR_W-1:0] bram_addr;
   logic [15:0]       conflict_cnt;

   bpdecode_bram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
      .ACLK(clk), .ARESET(ARESET),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
      .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // BRAM with RD_LAT-cycle registered read
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd0, rd1;
   always @(posedge clk) begin
      if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
      if (bram_en && !bram_we) rd0 <= mem[bram_addr];
      rd1 <= rd0;
   end
   assign bram_rdata = (RD_LAT == 1) ? rd0 : rd1;

   typedef struct {
      bit               own_d;
      logic [DATA_W-1:0] data;
      int               due;
   } exp_t;

   exp_t              q[$];
   logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
   int                cyc = 0;
   int                n_tests = 0;
   int                n_fail = 0;
   bit                mon_en = 0;
   bit                m_prio_d;
   int                m_hold;
   int                m_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (h_rvalid === 1'b1 || d_rvalid === 1'b1) begin
            chk("rvalid_onehot", 32'(h_rvalid & d_rvalid), 32'd0);
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rvalid_unexpected: got h=%0b d=%0b expected none (cycle %0d)",
                        h_rvalid, d_rvalid, cyc);
            end else begin
               e = q.pop_front();
               chk("rvalid_owner", 32'(d_rvalid), 32'(e.own_d));
               chk("rdata", d_rvalid ? d_rdata : h_rdata, e.data);
               chk("rvalid_cycle", cyc, e.due);
            end
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL rvalid_missing: got none expected owner_d=%0b at cycle %0d", e.own_d, e.due);
         end
      end
   end

   // One clock of stimulus; the model applies the arbitration rules for the coming edge
   task automatic step(input bit rst, input bit hr, input bit hw, input logic [ADDR_W-1:0] ha,
                       input logic [DATA_W-1:0] hd, input bit dr, input bit dw, input bit dl,
                       input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd, input bit clr);
      bit eh, ed, w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
      ARESET = rst; h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
      d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd; cnt_clr = clr;
      @(negedge clk);
      eh = 0;
      ed = 0;
      if (!rst) begin
         ed = dr && (!hr || (m_prio_d && m_hold < MAX_HOLD));
         eh = hr && !ed;
      end
      chk("h_gnt", 32'(h_gnt), 32'(eh));
      chk("d_gnt", 32'(d_gnt), 32'(ed));
      chk("bram_en", 32'(bram_en), 32'(eh | ed));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      w  = eh ? hw : dw;
      a  = eh ? ha : da;
      wd = eh ? hd : dd;
      if (eh || ed) begin
         chk("bram_we", 32'(bram_we), 32'(w));
         chk("bram_addr", 32'(bram_addr), 32'(a));
         if (w) chk("bram_wdata", bram_wdata, wd);
      end
      if (rst) begin
         m_prio_d = 1;
         m_hold   = 0;
         m_cnt    = 0;
      end else begin
         if (clr) m_cnt = 0;
         else if (hr && dr && m_cnt < 65535) m_cnt++;
         if (ed && dl && hr) m_hold++;
         else m_hold = 0;
         if (eh) m_prio_d = 1;
         else if (ed) m_prio_d = dl;
         if (eh || ed) begin
            if (w) ref_mem[a] = wd;
            else q.push_back('{ed, ref_mem[a], cyc + RD_LAT});
         end
      end
      if (rst) begin
         #1;
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      rd0 = '0;
      rd1 = '0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1;

      // reset with both requesting: no grants allowed
      repeat (3) step(1, 1, 0, 10'h1, '0, 1, 0, 0, 10'h2, '0, 0);
      chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);

      // single host write then read back
      step(0, 1, 1, 10'h010, 32'hA5A5_0001, 0, 0, 0, '0, '0, 0);
      step(0, 1, 0, 10'h010, '0, 0, 0, 0, '0, '0, 0);
      idle(RD_LAT + 1);

      // alternating conflict reads, no lock
      for (int i = 0; i < 6; i++)
         step(0, 1, 0, 10'(i), '0, 1, 0, 0, 10'h010, '0, 0);
      idle(RD_LAT + 1);
      chk("alt_conflict_cnt", 32'(conflict_cnt), 32'd6);

      // locked burst under contention
      for (int i = 0; i < 15; i++)
         step(0, 1, 0, 10'h010, '0, 1, 1, 1, 10'(i), 32'(i * 3 + 1), 0);

      // lock without contention, then host arrives as the lock drops
      for (int i = 0; i < 40; i++)
         step(0, 0, 0, '0, '0, 1, 1, 1, 10'(20 + i), 32'(i), 0);
      step(0, 1, 0, 10'h020, '0, 0, 0, 0, '0, '0, 0);
      idle(RD_LAT + 1);

      // reset mid-read: in-flight decoder read must vanish
      step(0, 0, 0, '0, '0, 1, 0, 0, 10'h005, '0, 0);
      step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
      idle(RD_LAT + 1);
      chk("post_rst_cnt", 32'(conflict_cnt), 32'd0);
      step(0, 1, 0, 10'h1, '0, 1, 0, 0, 10'h2, '0, 0);

      // randomized traffic on a small address window
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 99) == 0));
      end
      idle(RD_LAT + 1);

      // counter saturation then clear during a conflict
      step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
      for (int i = 0; i < 65540; i++)
         step(0, 1, 0, 10'h3, '0, 1, 0, 0, 10'h4, '0, 0);
      chk("sat_conflict_cnt", 32'(conflict_cnt), 32'hFFFF);
      step(0, 1, 0, 10'h3, '0, 1, 0, 0, 10'h4, '0, 1);
      chk("clr_conflict_cnt", 32'(conflict_cnt), 32'd0);
      idle(RD_LAT + 2);
      chk("rd_queue_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
